leapfrog_update: RTL and testbench

LEAPFROG_UPDATE -- requirements
Module: leapfrog_update

---
 rtl/nbody_pkg.sv | 32 +++
 rtl/leapfrog_update_if.sv | 40 ++++
 rtl/leapfrog_axis.sv | 41 ++++
 rtl/leapfrog_update.sv | 136 +++++++++++++
 tb/tb_leapfrog_update.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nbody_pkg.sv
// Shared N-body sizing defaults, body/vector payload types and integrator FSM states.
package nbody_pkg;

    localparam int unsigned BODIES_DEF     = 512;
    localparam int unsigned DATA_WIDTH_DEF = 64;
    localparam int unsigned DT_SHIFT_DEF   = 10;

    typedef struct packed {
        logic [DATA_WIDTH_DEF-1:0] x;
        logic [DATA_WIDTH_DEF-1:0] y;
        logic [DATA_WIDTH_DEF-1:0] z;
    } vec3_t;

    typedef struct packed {
        logic [DATA_WIDTH_DEF-1:0] px;
        logic [DATA_WIDTH_DEF-1:0] py;
        logic [DATA_WIDTH_DEF-1:0] pz;
        logic [DATA_WIDTH_DEF-1:0] vx;
        logic [DATA_WIDTH_DEF-1:0] vy;
        logic [DATA_WIDTH_DEF-1:0] vz;
    } body_state_t;

    typedef enum logic [2:0] {
        LF_IDLE   = 3'd0,
        LF_WAIT_A = 3'd1,
        LF_READ   = 3'd2,
        LF_CALC   = 3'd3,
        LF_WRITE  = 3'd4,
        LF_FIN    = 3'd5
    } lf_state_t;

endpackage

// File: rtl/leapfrog_update_if.sv
// Control, acceleration-stream and body-state memory bus of the leapfrog integrator.
interface leapfrog_update_if
    import nbody_pkg::*;
#(
    parameter int unsigned BODIES     = BODIES_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
);
    localparam int unsigned IW = $clog2(BODIES);

    logic                    start;
    logic                    busy;
    logic                    done;
    logic                    accel_valid;
    logic                    accel_ready;
    logic [IW-1:0]           accel_idx;
    logic [DATA_WIDTH-1:0]   accel_x;
    logic [DATA_WIDTH-1:0]   accel_y;
    logic [DATA_WIDTH-1:0]   accel_z;
    logic                    st_rd_en;
    logic [IW-1:0]           st_rd_addr;
    logic [6*DATA_WIDTH-1:0] st_rd_data;
    logic                    st_wr_en;
    logic [IW-1:0]           st_wr_addr;
    logic [6*DATA_WIDTH-1:0] st_wr_data;
    logic                    idx_err;
    logic [31:0]             step_count;

    modport slave (
        input  start, accel_valid, accel_idx, accel_x, accel_y, accel_z, st_rd_data,
        output busy, done, accel_ready, st_rd_en, st_rd_addr, st_wr_en, st_wr_addr,
               st_wr_data, idx_err, step_count
    );

    modport master (
        output start, accel_valid, accel_idx, accel_x, accel_y, accel_z, st_rd_data,
        input  busy, done, accel_ready, st_rd_en, st_rd_addr, st_wr_en, st_wr_addr,
               st_wr_data, idx_err, step_count
    );

endinterface

// File: rtl/leapfrog_axis.sv
// One-axis kick/drift: v' = v + (a >>> DT_SHIFT), p' = p + (v' >>> DT_SHIFT).
// Define LEAPFROG_SAT_EN to saturate both additions instead of wrapping.
module leapfrog_axis
    import nbody_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned DT_SHIFT   = DT_SHIFT_DEF
) (
    input  logic [DATA_WIDTH-1:0] acc,
    input  logic [DATA_WIDTH-1:0] pos,
    input  logic [DATA_WIDTH-1:0] vel,
    output logic [DATA_WIDTH-1:0] pos_next_c,
    output logic [DATA_WIDTH-1:0] vel_next_c
);
    localparam int unsigned MSB = DATA_WIDTH - 1;

    function automatic logic [DATA_WIDTH-1:0] add_w(input logic [DATA_WIDTH-1:0] x,
                                                     input logic [DATA_WIDTH-1:0] y);
        logic [DATA_WIDTH-1:0] s;
        s = x + y;
`ifdef LEAPFROG_SAT_EN
        // Overflow only when both operands share a sign the sum does not keep
        if ((x[MSB] == y[MSB]) && (s[MSB] != x[MSB]))
            s = x[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
`endif
        return s;
    endfunction

    logic [DATA_WIDTH-1:0] kick;
    logic [DATA_WIDTH-1:0] vel_new;
    logic [DATA_WIDTH-1:0] drift;

    always_comb begin
        kick       = DATA_WIDTH'($signed(acc) >>> DT_SHIFT);
        vel_new    = add_w(vel, kick);
        drift      = DATA_WIDTH'($signed(vel_new) >>> DT_SHIFT);
        vel_next_c = vel_new;
        pos_next_c = add_w(pos, drift);
    end

endmodule

// File: rtl/leapfrog_update.sv
// Leapfrog step sequencer: per body, take one acceleration, read state, kick/drift, write back.
// Saturating arithmetic is selected by defining LEAPFROG_SAT_EN (see leapfrog_axis).
module leapfrog_update
    import nbody_pkg::*;
#(
    parameter int unsigned BODIES     = BODIES_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned DT_SHIFT   = DT_SHIFT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    leapfrog_update_if.slave bus
);
    localparam int unsigned   IW   = $clog2(BODIES);
    localparam int unsigned   SW   = 6 * DATA_WIDTH;
    localparam logic [IW-1:0] LAST = IW'(BODIES - 1);

    lf_state_t                   state;
    logic [IW-1:0]               idx;
    logic [IW-1:0]               rd_addr;
    logic [IW-1:0]               wr_addr;
    logic                        busy;
    logic                        done;
    logic                        accel_ready;
    logic                        rd_en;
    logic                        wr_en;
    logic                        idx_err;
    logic [31:0]                 step_count;
    logic [2:0][DATA_WIDTH-1:0]  acc;
    logic [SW-1:0]               cur;
    logic [SW-1:0]               nxt;
    logic [SW-1:0]               wr_data;

    // State layout is {px,py,pz,vx,vy,vz}; axis k=0 is x
    for (genvar k = 0; k < 3; k++) begin : g_axis
        leapfrog_axis #(
            .DATA_WIDTH (DATA_WIDTH),
            .DT_SHIFT   (DT_SHIFT)
        ) u_axis (
            .acc        (acc[k]),
            .pos        (cur[(5-k)*DATA_WIDTH +: DATA_WIDTH]),
            .vel        (cur[(2-k)*DATA_WIDTH +: DATA_WIDTH]),
            .pos_next_c (nxt[(5-k)*DATA_WIDTH +: DATA_WIDTH]),
            .vel_next_c (nxt[(2-k)*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= LF_IDLE;
            idx         <= '0;
            rd_addr     <= '0;
            wr_addr     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            accel_ready <= 1'b0;
            rd_en       <= 1'b0;
            wr_en       <= 1'b0;
            idx_err     <= 1'b0;
            step_count  <= '0;
            acc         <= '0;
            cur         <= '0;
            wr_data     <= '0;
        end else begin
            done  <= 1'b0;
            rd_en <= 1'b0;
            wr_en <= 1'b0;
            case (state)
                LF_IDLE: begin
                    if (bus.start) begin
                        idx         <= '0;
                        idx_err     <= 1'b0;
                        busy        <= 1'b1;
                        accel_ready <= 1'b1;
                        state       <= LF_WAIT_A;
                    end
                end
                LF_WAIT_A: begin
                    if (bus.accel_valid && accel_ready) begin
                        acc         <= {bus.accel_z, bus.accel_y, bus.accel_x};
                        if (bus.accel_idx != idx) idx_err <= 1'b1;
                        rd_en       <= 1'b1;
                        rd_addr     <= idx;
                        accel_ready <= 1'b0;
                        state       <= LF_READ;
                    end
                end
                // First READ cycle carries the request; data lands on the second
                LF_READ: begin
                    if (!rd_en) begin
                        cur   <= bus.st_rd_data;
                        state <= LF_CALC;
                    end
                end
                LF_CALC: begin
                    wr_en   <= 1'b1;
                    wr_addr <= idx;
                    wr_data <= nxt;
                    state   <= LF_WRITE;
                end
                LF_WRITE: begin
                    if (idx == LAST) begin
                        done       <= 1'b1;
                        step_count <= step_count + 32'd1;
                        state      <= LF_FIN;
                    end else begin
                        idx         <= idx + IW'(1);
                        accel_ready <= 1'b1;
                        state       <= LF_WAIT_A;
                    end
                end
                LF_FIN: begin
                    busy  <= 1'b0;
                    state <= LF_IDLE;
                end
                default: begin
                    busy        <= 1'b0;
                    accel_ready <= 1'b0;
                    state       <= LF_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.accel_ready = accel_ready;
    assign bus.st_rd_en    = rd_en;
    assign bus.st_rd_addr  = rd_addr;
    assign bus.st_wr_en    = wr_en;
    assign bus.st_wr_addr  = wr_addr;
    assign bus.st_wr_data  = wr_data;
    assign bus.idx_err     = idx_err;
    assign bus.step_count  = step_count;

endmodule

// File: tb/tb_leapfrog_update.sv
// Directed bench for leapfrog_update: table of per-body vectors plus reset/stall/index sequences.
`timescale 1ns/1ps
module tb_leapfrog_update;
    import nbody_pkg::*;

    localparam int unsigned NB = 4;
    localparam int unsigned W  = 64;

    localparam logic [W-1:0] Z    = 64'h0000_0000_0000_0000;
    localparam logic [W-1:0] ONE  = 64'h0000_0001_0000_0000;
    localparam logic [W-1:0] TWO  = 64'h0000_0002_0000_0000;
    localparam logic [W-1:0] THR  = 64'h0000_0003_0000_0000;
    localparam logic [W-1:0] FOUR = 64'h0000_0004_0000_0000;
    localparam logic [W-1:0] HALF = 64'h0000_0000_8000_0000;
    localparam logic [W-1:0] N1   = 64'hFFFF_FFFF_0000_0000;
    localparam logic [W-1:0] N2   = 64'hFFFF_FFFE_0000_0000;
    localparam logic [W-1:0] N1H  = 64'hFFFF_FFFE_8000_0000;
    localparam logic [W-1:0] MAX  = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [W-1:0] MIN  = 64'h8000_0000_0000_0000;
    localparam logic [W-1:0] WRP  = 64'h8000_0000_FFFF_FFFF;
    localparam logic [W-1:0] MINM = 64'h7FFF_FFFF_0000_0000;
    localparam logic [W-1:0] RM1  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [W-1:0] K1   = 64'h0000_0400_0000_0000;
    localparam logic [W-1:0] NK1  = 64'hFFFF_FC00_0000_0000;
    localparam logic [W-1:0] EPS  = 64'h0000_0000_0040_0000;
    localparam logic [W-1:0] NEPS = 64'hFFFF_FFFF_FFC0_0000;

    typedef struct packed {
        vec3_t p;
        vec3_t v;
        vec3_t a;
        vec3_t ep;
        vec3_t ev;
    } rec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    leapfrog_update_if #(.BODIES(NB), .DATA_WIDTH(W)) if0 ();
    leapfrog_update_if #(.BODIES(NB), .DATA_WIDTH(W)) if1 ();

    leapfrog_update #(.BODIES(NB), .DATA_WIDTH(W), .DT_SHIFT(0)) u_dut0 (
        .clk (clk), .rst (rst), .bus (if0.slave));
    leapfrog_update #(.BODIES(NB), .DATA_WIDTH(W), .DT_SHIFT(10)) u_dut1 (
        .clk (clk), .rst (rst), .bus (if1.slave));

    logic [1:0]   start_d;
    logic [1:0]   valid_d;
    logic [1:0]   idx_d;
    logic [W-1:0] ax_d, ay_d, az_d;

    assign if0.start       = start_d[0];
    assign if1.start       = start_d[1];
    assign if0.accel_valid = valid_d[0];
    assign if1.accel_valid = valid_d[1];
    assign if0.accel_idx   = idx_d;
    assign if1.accel_idx   = idx_d;
    assign if0.accel_x     = ax_d;
    assign if1.accel_x     = ax_d;
    assign if0.accel_y     = ay_d;
    assign if1.accel_y     = ay_d;
    assign if0.accel_z     = az_d;
    assign if1.accel_z     = az_d;

    logic [1:0]  busy_w, ready_w, rd_en_w, wr_en_w, err_w;
    logic [1:0]  rd_addr_w [2];
    logic [1:0]  wr_addr_w [2];
    logic [31:0] sc_w [2];

    assign busy_w       = {if1.busy, if0.busy};
    assign ready_w      = {if1.accel_ready, if0.accel_ready};
    assign rd_en_w      = {if1.st_rd_en, if0.st_rd_en};
    assign wr_en_w      = {if1.st_wr_en, if0.st_wr_en};
    assign err_w        = {if1.idx_err, if0.idx_err};
    assign rd_addr_w[0] = if0.st_rd_addr;
    assign rd_addr_w[1] = if1.st_rd_addr;
    assign wr_addr_w[0] = if0.st_wr_addr;
    assign wr_addr_w[1] = if1.st_wr_addr;
    assign sc_w[0]      = if0.step_count;
    assign sc_w[1]      = if1.step_count;

    // Body-state memories with one-cycle read latency, plus event counters
    body_state_t mem0 [NB];
    body_state_t mem1 [NB];
    logic [1:0]  ld_en;
    logic [1:0]  ld_addr;
    body_state_t ld_data;
    int wr_cnt [2]    = '{0, 0};
    int rd_cnt [2]    = '{0, 0};
    int done_cnt [2]  = '{0, 0};
    int clash_cnt [2] = '{0, 0};

    always @(posedge clk) begin
        if (ld_en[0]) mem0[ld_addr] <= ld_data;
        else if (if0.st_wr_en) mem0[if0.st_wr_addr] <= body_state_t'(if0.st_wr_data);
        if (ld_en[1]) mem1[ld_addr] <= ld_data;
        else if (if1.st_wr_en) mem1[if1.st_wr_addr] <= body_state_t'(if1.st_wr_data);
        if (if0.st_rd_en) if0.st_rd_data <= mem0[if0.st_rd_addr];
        if (if1.st_rd_en) if1.st_rd_data <= mem1[if1.st_rd_addr];
        if (if0.st_wr_en) wr_cnt[0] <= wr_cnt[0] + 1;
        if (if1.st_wr_en) wr_cnt[1] <= wr_cnt[1] + 1;
        if (if0.st_rd_en) rd_cnt[0] <= rd_cnt[0] + 1;
        if (if1.st_rd_en) rd_cnt[1] <= rd_cnt[1] + 1;
        if (if0.done) done_cnt[0] <= done_cnt[0] + 1;
        if (if1.done) done_cnt[1] <= done_cnt[1] + 1;
        if (if0.st_rd_en && if0.st_wr_en) clash_cnt[0] <= clash_cnt[0] + 1;
        if (if1.st_rd_en && if1.st_wr_en) clash_cnt[1] <= clash_cnt[1] + 1;
    end

    int   errs   = 0;
    int   checks = 0;
    rec_t tbl [12];

    function automatic vec3_t v3(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic [W-1:0] z);
        vec3_t r;
        r.x = x; r.y = y; r.z = z;
        return r;
    endfunction

    function automatic rec_t mk_rec(input vec3_t p, input vec3_t v, input vec3_t a,
                                    input vec3_t ep, input vec3_t ev);
        rec_t r;
        r.p = p; r.v = v; r.a = a; r.ep = ep; r.ev = ev;
        return r;
    endfunction

    function automatic body_state_t mk_state(input vec3_t p, input vec3_t v);
        body_state_t s;
        s.px = p.x; s.py = p.y; s.pz = p.z;
        s.vx = v.x; s.vy = v.y; s.vz = v.z;
        return s;
    endfunction

    function automatic body_state_t mem_rd(input int d, input int a);
        return (d == 0) ? mem0[a] : mem1[a];
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic chk_state(input string name, input body_state_t got, input body_state_t exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic load_row(input int d, input int a, input int r);
        ld_en     = '0;
        ld_en[d]  = 1'b1;
        ld_addr   = 2'(a);
        ld_data   = mk_state(tbl[r].p, tbl[r].v);
        @(negedge clk);
        ld_en     = '0;
    endtask

    task automatic start_step(input int d);
        start_d[d] = 1'b1;
        @(negedge clk);
        start_d[d] = 1'b0;
        chk("start_busy", 32'(busy_w[d]), 32'd1);
        chk("start_ready", 32'(ready_w[d]), 32'd1);
        chk("start_idx_err_clear", 32'(err_w[d]), 32'd0);
    endtask

    // Handshake one sample and track it to the write (or stop in CALC when abort)
    task automatic feed(input int d, input int b, input int idx, input int r, input bit abort);
        int t;
        t = 0;
        while (!ready_w[d] && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!ready_w[d]) begin
            chk("accel_ready_timeout", 32'(ready_w[d]), 32'd1);
            return;
        end
        valid_d[d] = 1'b1;
        idx_d      = 2'(idx);
        ax_d       = tbl[r].a.x;
        ay_d       = tbl[r].a.y;
        az_d       = tbl[r].a.z;
        @(negedge clk);
        valid_d    = '0;
        chk($sformatf("rd_en_b%0d", b), 32'(rd_en_w[d]), 32'd1);
        chk($sformatf("rd_addr_b%0d", b), 32'(rd_addr_w[d]), 32'(b));
        chk("ready_drop", 32'(ready_w[d]), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("wr_early", 32'(wr_en_w[d]), 32'd0);
        end
        if (abort) return;
        @(negedge clk);
        chk($sformatf("wr_en_b%0d", b), 32'(wr_en_w[d]), 32'd1);
        chk($sformatf("wr_addr_b%0d", b), 32'(wr_addr_w[d]), 32'(b));
    endtask

    task automatic wait_idle(input int d);
        int t;
        t = 0;
        while (busy_w[d] && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("busy_clear", 32'(busy_w[d]), 32'd0);
    endtask

    task automatic check_rows(input int d, input int base);
        for (int b = 0; b < int'(NB); b++)
            chk_state($sformatf("row%0d", base + b), mem_rd(d, b),
                      mk_state(tbl[base + b].ep, tbl[base + b].ev));
    endtask

    task automatic run_step(input int d, input int base, input int bad);
        int sc, dc;
        for (int b = 0; b < int'(NB); b++) load_row(d, b, base + b);
        sc = int'(sc_w[d]);
        dc = done_cnt[d];
        start_step(d);
        for (int b = 0; b < int'(NB); b++) feed(d, b, (b == bad) ? b + 1 : b, base + b, 1'b0);
        wait_idle(d);
        check_rows(d, base);
        chk("done_pulses", 32'(done_cnt[d] - dc), 32'd1);
        chk("step_count", sc_w[d], 32'(sc + 1));
    endtask

    initial begin
        int sc, dc, wc, rc, t;
        start_d = '0; valid_d = '0; idx_d = '0;
        ax_d = Z; ay_d = Z; az_d = Z;
        ld_en = '0; ld_addr = '0; ld_data = '0;

        // DT_SHIFT=0 rows (DUT0)
        for (int i = 0; i < 4; i++)
            tbl[i] = mk_rec(v3(ONE, ONE, ONE), v3(Z, Z, Z), v3(ONE, ONE, ONE),
                            v3(TWO, TWO, TWO), v3(ONE, ONE, ONE));
        tbl[4] = mk_rec(v3(Z, Z, Z), v3(N2, THR, Z), v3(HALF, N1, Z),
                        v3(N1H, TWO, Z), v3(N1H, TWO, Z));
`ifdef LEAPFROG_SAT_EN
        tbl[5] = mk_rec(v3(Z, Z, Z), v3(MAX, MAX, Z), v3(ONE, Z, N1),
                        v3(MAX, MAX, N1), v3(MAX, MAX, N1));
        tbl[6] = mk_rec(v3(MAX, MIN, THR), v3(ONE, N1, Z), v3(Z, Z, ONE),
                        v3(MAX, MIN, FOUR), v3(ONE, N1, ONE));
`else
        tbl[5] = mk_rec(v3(Z, Z, Z), v3(MAX, MAX, Z), v3(ONE, Z, N1),
                        v3(WRP, MAX, N1), v3(WRP, MAX, N1));
        tbl[6] = mk_rec(v3(MAX, MIN, THR), v3(ONE, N1, Z), v3(Z, Z, ONE),
                        v3(WRP, MINM, FOUR), v3(ONE, N1, ONE));
`endif
        tbl[7] = mk_rec(v3(64'd5, 64'd7, Z), v3(64'd3, RM1, Z), v3(64'hFFFF_FFFF_FFFF_FFFC, 64'd2, Z),
                        v3(64'd4, 64'd8, Z), v3(RM1, 64'd1, Z));
        // DT_SHIFT=10 rows (DUT1)
        tbl[8]  = mk_rec(v3(Z, Z, Z), v3(Z, Z, Z), v3(K1, NK1, RM1),
                         v3(EPS, NEPS, RM1), v3(ONE, N1, RM1));
        tbl[9]  = mk_rec(v3(ONE, Z, Z), v3(ONE, Z, Z), v3(Z, Z, Z),
                         v3(64'h0000_0001_0040_0000, Z, Z), v3(ONE, Z, Z));
        tbl[10] = mk_rec(v3(Z, Z, Z), v3(Z, Z, Z), v3(64'd1023, Z, Z),
                         v3(Z, Z, Z), v3(Z, Z, Z));
        tbl[11] = mk_rec(v3(Z, Z, Z), v3(N1, Z, Z), v3(Z, Z, Z),
                         v3(NEPS, Z, Z), v3(N1, Z, Z));

        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy_w[0]), 32'd0);
        chk("rst_done", 32'(if0.done), 32'd0);
        chk("rst_ready", 32'(ready_w[0]), 32'd0);
        chk("rst_rd_en", 32'(rd_en_w[0]), 32'd0);
        chk("rst_wr_en", 32'(wr_en_w[0]), 32'd0);
        chk("rst_idx_err", 32'(err_w[0]), 32'd0);
        chk("rst_step_count", sc_w[0], 32'd0);
        chk("rst_step_count1", sc_w[1], 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Reset while body 2 sits in CALC
        for (int b = 0; b < int'(NB); b++) load_row(0, b, b);
        start_step(0);
        feed(0, 0, 0, 0, 1'b0);
        feed(0, 1, 1, 1, 1'b0);
        feed(0, 2, 2, 2, 1'b1);
        wc  = wr_cnt[0];
        rst = 1'b0;
        #1;
        chk("abort_busy", 32'(busy_w[0]), 32'd0);
        chk("abort_wr_en", 32'(wr_en_w[0]), 32'd0);
        chk("abort_ready", 32'(ready_w[0]), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk("abort_no_writes", 32'(wr_cnt[0] - wc), 32'd0);
        chk("abort_step_count", sc_w[0], 32'd0);
        chk("abort_idle", 32'(busy_w[0]), 32'd0);

        run_step(0, 0, -1);
        run_step(1, 8, -1);
        run_step(0, 4, -1);

        // Wrong accel_idx on body 1: flagged, write still lands at address 1
        run_step(0, 0, 1);
        chk("idx_err_set", 32'(err_w[0]), 32'd1);

        // Stalled stream with a stray start while busy
        for (int b = 0; b < int'(NB); b++) load_row(0, b, b);
        sc = int'(sc_w[0]);
        dc = done_cnt[0];
        start_step(0);
        feed(0, 0, 0, 0, 1'b0);
        t = 0;
        while (!ready_w[0] && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("stall_ready", 32'(ready_w[0]), 32'd1);
        rc = rd_cnt[0];
        for (int k = 0; k < 20; k++) begin
            if (k == 10) start_d[0] = 1'b1;
            @(negedge clk);
            start_d[0] = 1'b0;
        end
        chk("stall_no_reads", 32'(rd_cnt[0] - rc), 32'd0);
        chk("stall_busy", 32'(busy_w[0]), 32'd1);
        chk("stall_ready_held", 32'(ready_w[0]), 32'd1);
        for (int b = 1; b < int'(NB); b++) feed(0, b, b, b, 1'b0);
        wait_idle(0);
        check_rows(0, 0);
        chk("stall_idx_err", 32'(err_w[0]), 32'd0);
        chk("stall_done_pulses", 32'(done_cnt[0] - dc), 32'd1);
        chk("stall_step_count", sc_w[0], 32'(sc + 1));

        chk("rd_wr_overlap", 32'(clash_cnt[0] + clash_cnt[1]), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
